// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler: drains NSRC first-word-fall-through FIFOs into one
// valid/ready stream, one source per burst, each word tagged with its source index.
module fifo_rr_sched #(
  parameter int NSRC   = 4,
  parameter int DATAW  = 8,
  parameter int SRCW   = $clog2(NSRC),
  parameter int BURSTW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       i_empty,
  input  logic [NSRC*DATAW-1:0] i_rd_data,
  output logic [NSRC-1:0]       o_rd_en,
  input  logic [BURSTW-1:0]     i_burst_max,
  output logic                  o_valid,
  output logic [DATAW-1:0]      o_data,
  output logic [SRCW-1:0]       o_src,
  input  logic                  i_ready,
  output logic                  o_busy
);
  typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [SRCW-1:0]   grant_r, grant_s, last_r, last_s, pick_s, idx_s;
  logic [BURSTW-1:0] cnt_r, cnt_s, lim_r, lim_s;
  logic              found_s, take_s, pop_s;
  logic [DATAW-1:0]  src_data_s [NSRC];

  // Search order starts just after the last served source, so every waiting source is reached.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 1; i <= NSRC; i++) begin
      idx_s = SRCW'((int'(last_r) + i) % NSRC);
      if (!found_s && !i_empty[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Unpack the flat data bus into per-source words.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      src_data_s[k] = i_rd_data[k*DATAW +: DATAW];
    end
  end

  // Next-state logic and the pop strobe; a pop is only issued when the output slot frees up.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    lim_s   = lim_r;
    take_s  = !o_valid || i_ready;
    pop_s   = 1'b0;
    o_rd_en = '0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = pick_s;
          lim_s   = (i_burst_max == BURSTW'(0)) ? BURSTW'(1) : i_burst_max;
          cnt_s   = BURSTW'(0);
          state_s = SERVE;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE: begin
        pop_s            = take_s && !i_empty[grant_r];
        o_rd_en[grant_r] = pop_s;
        if (pop_s) begin
          cnt_s = cnt_r + BURSTW'(1);
        end else begin
          cnt_s = cnt_r;
        end
        // Burst limit reached and source drained in the same cycle still leave only once.
        if ((pop_s && (cnt_s == lim_r)) || i_empty[grant_r]) begin
          state_s = IDLE;
          last_s  = grant_r;
        end else begin
          state_s = SERVE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Scheduler state registers; last resets to NSRC-1 so source 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= SRCW'(NSRC - 1);
      cnt_r   <= BURSTW'(0);
      lim_r   <= BURSTW'(0);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      lim_r   <= lim_s;
    end
  end

  // Output register: load on pop, drop valid once accepted, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
    end else if (pop_s) begin
      o_valid <= 1'b1;
      o_data  <= src_data_s[grant_r];
      o_src   <= grant_r;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

  assign o_busy = (state_r == SERVE);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: behavioural FWFT FIFOs feed the scheduler and a
// transaction-level round-robin model predicts the full (source, word) output order.
module tb_fifo_rr_sched;
  localparam int NSRC   = 4;
  localparam int DATAW  = 8;
  localparam int SRCW   = 2;
  localparam int BURSTW = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NSRC-1:0]       i_empty;
  logic [NSRC*DATAW-1:0] i_rd_data;
  logic [NSRC-1:0]       o_rd_en;
  logic [BURSTW-1:0]     i_burst_max;
  logic                  o_valid;
  logic [DATAW-1:0]      o_data;
  logic [SRCW-1:0]       o_src;
  logic                  i_ready;
  logic                  o_busy;

  fifo_rr_sched #(.NSRC(NSRC), .DATAW(DATAW), .SRCW(SRCW), .BURSTW(BURSTW)) dut (
    .clk(clk), .rst_n(rst_n), .i_empty(i_empty), .i_rd_data(i_rd_data),
    .o_rd_en(o_rd_en), .i_burst_max(i_burst_max), .o_valid(o_valid),
    .o_data(o_data), .o_src(o_src), .i_ready(i_ready), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  logic [DATAW-1:0]      mem [NSRC][64];
  int                    hd [NSRC];
  int                    tl [NSRC];
  logic [SRCW+DATAW-1:0] expq [$];
  int                    mlast;

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NSRC; k++) begin
      i_empty[k] = (hd[k] == tl[k]);
      i_rd_data[k*DATAW +: DATAW] = (hd[k] == tl[k]) ? 8'h00 : mem[k][hd[k][5:0]];
    end
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < NSRC; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
    drive_fifos();
  endtask

  task automatic push(input int k, input logic [DATAW-1:0] d);
    mem[k][tl[k][5:0]] = d;
    tl[k]++;
  endtask

  // Round-robin model: from the preloaded contents, grant the next non-empty
  // source after the last one and take min(limit, remaining) words from it.
  task automatic plan(input int lim_first, input int lim_rest);
    int c [NSRC];
    int p [NSRC];
    int total, g, lim;
    bit first;
    total = 0;
    for (int k = 0; k < NSRC; k++) begin
      c[k] = tl[k] - hd[k];
      p[k] = hd[k];
      total += c[k];
    end
    first = 1'b1;
    while (total > 0) begin
      g = -1;
      for (int i = 1; i <= NSRC; i++) begin
        if (g < 0 && c[(mlast + i) % NSRC] > 0) g = (mlast + i) % NSRC;
      end
      lim = first ? lim_first : lim_rest;
      if (lim == 0) lim = 1;
      first = 1'b0;
      for (int j = 0; j < lim && c[g] > 0; j++) begin
        expq.push_back({SRCW'(g), mem[g][p[g][5:0]]});
        p[g]++;
        c[g]--;
        total--;
      end
      mlast = g;
    end
  endtask

  // One clock: sample just before the edge, advance, then apply FIFO pops.
  task automatic tick();
    logic [NSRC-1:0]       en;
    logic                  acc, stall;
    logic [DATAW-1:0]      d;
    logic [SRCW-1:0]       s;
    logic [SRCW+DATAW-1:0] e;
    #3;
    en    = o_rd_en;
    acc   = o_valid && i_ready;
    stall = o_valid && !i_ready;
    d     = o_data;
    s     = o_src;
    if (en != '0) begin
      check(32'(en & i_empty), 32'd0, "rd_en_on_empty");
      check(32'($countones(en)), 32'd1, "rd_en_onehot");
    end
    if (stall) check(32'(en), 32'd0, "rd_en_in_stall");
    if (acc) begin
      check(32'(expq.size() > 0), 32'd1, "word_expected");
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check(32'({s, d}), 32'(e), "word_order");
      end
    end
    @(posedge clk);
    #1;
    if (stall) check(32'({o_valid, o_src, o_data}), 32'({1'b1, s, d}), "stall_hold");
    for (int k = 0; k < NSRC; k++) begin
      if (en[k] && hd[k] != tl[k]) hd[k]++;
    end
    drive_fifos();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    check(32'(o_valid), 32'd1, "valid_timeout");
  endtask

  // mode 0: ready high, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic drain(input int mode);
    int n;
    n = 0;
    while ((expq.size() > 0 || o_valid) && n < 2000) begin
      case (mode)
        1:       i_ready = 1'($urandom_range(0, 1));
        2:       i_ready = (n % 4 == 0) || (n % 4 == 3);
        default: i_ready = 1'b1;
      endcase
      tick();
      n++;
    end
    i_ready = 1'b1;
    check(32'(expq.size()), 32'd0, "drain_left");
    n = 0;
    while (o_busy && n < 8) begin
      tick();
      n++;
    end
    check(32'(o_busy), 32'd0, "busy_end");
  endtask

  initial begin
    int gaps, n;
    rst_n       = 1'b0;
    i_ready     = 1'b1;
    i_burst_max = 3'd4;
    mlast       = NSRC - 1;
    clear_fifos();
    #12;
    check(32'(o_valid), 32'd0, "rst_valid");
    check(32'(o_data),  32'd0, "rst_data");
    check(32'(o_src),   32'd0, "rst_src");
    check(32'(o_busy),  32'd0, "rst_busy");
    check(32'(o_rd_en), 32'd0, "rst_rd_en");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    check(32'(o_busy), 32'd0, "idle_no_data");

    // Single source, latency and back-to-back words
    push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
    drive_fifos();
    plan(4, 4);
    tick();
    check(32'(o_valid), 32'd0, "latency_edge1_valid");
    check(32'(o_busy),  32'd1, "latency_edge1_busy");
    tick();
    check(32'(o_valid), 32'd1, "latency_edge2_valid");
    check(32'({o_src, o_data}), 32'({2'd2, 8'hA1}), "first_word");
    tick();
    check(32'({o_valid, o_src, o_data}), 32'({1'b1, 2'd2, 8'hA2}), "second_word");
    drain(0);

    // Rotation: 4 x 8 words, burst 2, one bubble between grants
    for (int k = 0; k < NSRC; k++)
      for (int j = 0; j < 8; j++) push(k, 8'($urandom));
    drive_fifos();
    i_burst_max = 3'd2;
    plan(2, 2);
    wait_valid();
    gaps = 0;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      if (!o_valid) gaps++;
      tick();
      n++;
    end
    check(32'(gaps), 32'd15, "rotation_bubbles");
    drain(0);

    // Backpressure with ready pattern 1,0,0,1
    for (int j = 0; j < 5; j++) begin
      push(1, 8'($urandom));
      push(3, 8'($urandom));
    end
    drive_fifos();
    i_burst_max = 3'd3;
    plan(3, 3);
    drain(2);

    // burst_max 0 behaves as 1
    for (int j = 0; j < 3; j++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
    end
    drive_fifos();
    i_burst_max = 3'd0;
    plan(0, 0);
    drain(0);

    // burst_max changed 2 -> 5 during the first burst
    for (int k = 0; k < NSRC; k++)
      for (int j = 0; j < 7; j++) push(k, 8'($urandom));
    drive_fifos();
    i_burst_max = 3'd2;
    plan(2, 5);
    wait_valid();
    i_burst_max = 3'd5;
    drain(0);

    // Early drain: one word in FIFO 1, more in FIFO 2, long burst
    push(1, 8'h5A);
    for (int j = 0; j < 3; j++) push(2, 8'($urandom));
    drive_fifos();
    i_burst_max = 3'd7;
    plan(7, 7);
    drain(0);

    // Randomized contents, burst limits and backpressure
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NSRC; k++) begin
        n = int'($urandom_range(0, 5));
        for (int j = 0; j < n; j++) push(k, 8'($urandom));
      end
      drive_fifos();
      i_burst_max = 3'($urandom_range(0, 7));
      plan(int'(i_burst_max), int'(i_burst_max));
      drain(1);
    end

    // Reset mid-burst with a word held in the output register
    for (int k = 0; k < NSRC; k++)
      for (int j = 0; j < 4; j++) push(k, 8'($urandom) | 8'h01);
    drive_fifos();
    i_burst_max = 3'd4;
    plan(4, 4);
    wait_valid();
    i_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check(32'(o_valid), 32'd0, "midrst_valid");
    check(32'(o_data),  32'd0, "midrst_data");
    check(32'(o_src),   32'd0, "midrst_src");
    check(32'(o_busy),  32'd0, "midrst_busy");
    check(32'(o_rd_en), 32'd0, "midrst_rd_en");
    expq.delete();
    mlast = NSRC - 1;
    clear_fifos();
    i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(3, 8'h31); push(3, 8'h32);
    push(0, 8'h01); push(0, 8'h02);
    drive_fifos();
    plan(4, 4);
    drain(0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fifo_rr_sched.md
# fifo_rr_sched

Round-robin read scheduler that drains NSRC first-word-fall-through FIFOs into one shared valid/ready output stream. It sits downstream of a bank of `fifo` instances and owns their `i_rd_en` inputs. It grants one non-empty source at a time for a configurable burst, then rotates. Each output word is tagged with the index of the FIFO it came from.

## Interface
- NSRC, 4: number of source FIFOs (2..16).
- DATAW, 8: data width; must match the source FIFOs.
- SRCW, $clog2(NSRC): width of the source index.
- BURSTW, 3: width of the burst-limit config.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_empty  in  NSRC  per-source `o_rd_empty`; bit k is FIFO k.
- i_rd_data  in  NSRC*DATAW  per-source `o_rd_data`; source k occupies bits [k*DATAW +: DATAW]; valid whenever its empty bit is 0.
- o_rd_en  out  NSRC  per-source pop strobe, one-hot or zero.
- i_burst_max  in  BURSTW  maximum words per grant; value 0 is treated as 1.
- o_valid  out  1  output word valid.
- o_data  out  DATAW  output word.
- o_src  out  SRCW  source index of o_data.
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_busy  out  1  state is SERVE.

## Operation
- FSM states: IDLE, SERVE.
- IDLE:
  - If any i_empty bit is 0, select the first non-empty source searching from last+1 upward, wrapping modulo NSRC.
  - Register it as grant, latch burst_lim = max(i_burst_max, 1), clear cnt, and go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - Define take = !o_valid || i_ready.
  - o_rd_en[grant] = take && !i_empty[grant]. This is combinational. All other bits are 0.
  - On a pop, the output register loads o_data = i_rd_data[grant] and o_src = grant, o_valid is set to 1, and cnt increments.
  - Leave for IDLE, with last <= grant, when either condition holds:
    - a pop brings cnt to burst_lim;
    - i_empty[grant] = 1 at a clock edge (source drained).
- Output register, in any state:
  - If o_valid && i_ready with no new pop, o_valid <= 0.
  - While o_valid && !i_ready, o_data and o_src hold stable.
- No pop ever occurs from an empty FIFO.
- No source is popped while the output is stalled.
- i_burst_max is sampled only on the IDLE->SERVE transition. Changing it mid-burst has no effect on the current burst.
- cnt is BURSTW bits wide and compares against burst_lim only, so it never wraps.
- Fairness: a source that stays non-empty is granted within NSRC-1 other grants.

## Timing
- Reset values: state IDLE, last = NSRC-1 (source 0 has first priority), grant 0, cnt 0, o_valid 0, o_data 0, o_src 0, o_rd_en 0, o_busy 0.
- Latency, from the edge where i_empty[k] is first seen 0 while in IDLE:
  - grant at edge +1;
  - o_rd_en[k] during the following cycle;
  - o_valid at edge +2.
- Steady-state throughput within a burst is 1 word per cycle while i_ready = 1.
- Each grant switch costs one IDLE bubble cycle.
- Simultaneous events:
  - A downstream accept and a new pop in the same cycle leave o_valid at 1 with the new data.
  - When the final pop of a burst reaches the limit and the source also goes empty, the FSM returns to IDLE exactly once.
- An asserted reset mid-burst asynchronously clears all state and outputs.
- A word popped but not yet accepted is discarded by reset. The source FIFOs are expected to be reset together with this block.

## Test plan
- Single source: NSRC=4, burst_max=4, i_ready=1, 3 words (0xA1, 0xA2, 0xA3) in FIFO 2 -> o_valid first high 2 cycles after empty falls; output A1, A2, A3 on consecutive cycles with o_src=2; then IDLE and o_busy=0.
- Rotation: all 4 FIFOs hold 8 words, burst_max=2 -> o_src sequence 0,0,1,1,2,2,3,3,0,0,…; exactly one bubble cycle between pairs; all 32 words in per-source order.
- Backpressure: i_ready toggles 1,0,0,1 during a burst -> o_data and o_src stable while stalled; o_rd_en is 0 during stall cycles; no word lost or duplicated.
- Edge configs: burst_max=0 behaves as 1 (one word per grant). burst_max changed from 2 to 5 mid-burst -> the current burst ends at 2 and the next grant uses 5.
- Early drain: FIFO 1 holds 1 word and burst_max=7 -> 1 word out, release, and the next grant goes to FIFO 2 if it is non-empty. o_rd_en is never asserted with i_empty=1 (checked by assertion throughout).
- Reset mid-burst with o_valid=1 -> all outputs 0 immediately. After release, the scheduler restarts at source 0 priority.
